// File: rtl/fact_mmio_responder_pkg.sv
// Shared constants for the factorial MMIO accelerator: register addresses,
// FSM state encoding and the default largest legal n.
package fact_pkg;

  localparam logic [1:0] ADDR_N      = 2'b00;
  localparam logic [1:0] ADDR_GO     = 2'b01;
  localparam logic [1:0] ADDR_STATUS = 2'b10;
  localparam logic [1:0] ADDR_RESULT = 2'b11;

  localparam int MAX_N_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fact_mmio_responder_if.sv
// CPU-side register bus of the factorial accelerator: pre-qualified write
// strobe, word select, write data and combinational read data.
interface fact_mmio_responder_if #(
  parameter int w = 32
);
  logic         WE;
  logic [1:0]   A;
  logic [w-1:0] WD;
  logic [w-1:0] RD;

  modport master (output WE, output A, output WD, input RD);
  modport slave  (input WE, input A, input WD, output RD);
endinterface

// File: rtl/fact_mmio_responder_datapath.sv
// Factorial datapath: cnt down-counter, running product and result register,
// sequenced by load/step/store/clear strobes from the control FSM.
module fact_datapath #(
  parameter int w  = 32,
  parameter int NW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_step,
  input  logic          i_store,
  input  logic          i_clr,
  input  logic [NW-1:0] i_n,
  output logic          o_last,
  output logic [w-1:0]  o_result
);

  logic [NW-1:0] r_cnt;
  logic [w-1:0]  r_product;
  logic [w-1:0]  r_result;
  logic [w-1:0]  w_prod_next;

  assign w_prod_next = r_product * w'(r_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_product <= '0;
      r_result  <= '0;
    end else begin
      if (i_load) begin
        r_cnt     <= i_n;
        r_product <= w'(1);
      end else if (i_step) begin
        r_product <= w_prod_next;
        r_cnt     <= r_cnt - NW'(1);
      end
      if (i_store) begin
        r_result <= r_product;
      end else if (i_clr) begin
        r_result <= '0;
      end
    end
  end

  // cnt of 0 or 1 means the product is final
  assign o_last   = (r_cnt[NW-1:1] == '0);
  assign o_result = r_result;

endmodule

// File: rtl/fact_mmio_responder.sv
// Memory-mapped factorial accelerator: register decode, control FSM and read mux.
// Optional completion interrupt output irq enabled by defining FACT_IRQ_EN.
module fact_mmio_responder
  import fact_pkg::*;
#(
  parameter int w     = 32,
  parameter int NW    = 4,
  parameter int MAX_N = MAX_N_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  fact_mmio_responder_if.slave  bus
`ifdef FACT_IRQ_EN
  ,
  output logic                  irq
`endif
);

  state_t        r_state, w_state_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;
  logic [NW-1:0] r_n;
  logic          w_go, w_over;
  logic          w_load, w_step, w_store, w_clr;
  logic          w_last;
  logic [w-1:0]  w_result;

  assign w_go   = bus.WE && (bus.A == ADDR_GO) && bus.WD[0];
  assign w_over = int'(r_n) > MAX_N;

  fact_datapath #(.w(w), .NW(NW)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_store  (w_store),
    .i_clr    (w_clr),
    .i_n      (r_n),
    .o_last   (w_last),
    .o_result (w_result)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_store     = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (w_go) begin
          w_done_nxt = 1'b0;
          w_err_nxt  = 1'b0;
          if (w_over) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
            w_clr       = 1'b1;
          end else begin
            w_state_nxt = BUSY;
            w_load      = 1'b1;
          end
        end
      end
      BUSY: begin
        if (w_last) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
          w_store     = 1'b1;
        end else begin
          w_step = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_n     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (bus.WE && (bus.A == ADDR_N)) begin
        r_n <= bus.WD[NW-1:0];
      end
    end
  end

  always_comb begin
    bus.RD = '0;
    case (bus.A)
      ADDR_N:      bus.RD[NW-1:0] = r_n;
      ADDR_GO:     bus.RD[0]      = (r_state == BUSY);
      ADDR_STATUS: bus.RD[1:0]    = {r_err, r_done};
      ADDR_RESULT: bus.RD         = w_result;
      default:     bus.RD         = '0;
    endcase
  end

`ifdef FACT_IRQ_EN
  logic r_irq;

  // An error GO issued from DONE keeps done high across the edge, so the
  // completion strobes (store/clear) mark the rising edge of done instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else if (w_store || w_clr) begin
      r_irq <= 1'b1;
    end else if (bus.WE && (bus.A == ADDR_STATUS)) begin
      r_irq <= 1'b0;
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_fact_mmio_responder.sv
// Self-checking bench for fact_mmio_responder: directed scenarios plus random
// jobs compared against a plain-arithmetic factorial reference.
module tb_fact_mmio_responder;
  import fact_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  fact_mmio_responder_if #(.w(32)) bus ();
`ifdef FACT_IRQ_EN
  logic irq;
`endif

  fact_mmio_responder #(.w(32), .NW(4), .MAX_N(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FACT_IRQ_EN
    ,
    .irq (irq)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fact_ref(int n);
    longint p = 1;
    for (int i = 2; i <= n; i++) p = p * i;
    return p[31:0];
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the write lands on the following rising edge.
  task automatic wr(logic [1:0] a, logic [31:0] d);
    bus.WE = 1'b1;
    bus.A  = a;
    bus.WD = d;
    @(negedge clk);
    bus.WE = 1'b0;
  endtask

  task automatic rd_chk(string tag, logic [1:0] a, logic [31:0] exp);
    bus.A = a;
    #1;
    check(tag, bus.RD, exp);
  endtask

  task automatic run_job(int n, logic [31:0] go_data);
    logic        err;
    logic [31:0] res;
    int          lat;
    err = (n > 12);
    res = err ? 32'd0 : fact_ref(n);
    lat = err ? 0 : ((n < 1) ? 1 : n);
    wr(ADDR_N, 32'(n) | ($urandom & 32'hFFFF_FFF0));
    rd_chk("n_readback", ADDR_N, 32'(n));
    wr(ADDR_GO, go_data | 32'd1);
    for (int i = 0; i < lat; i++) begin
      rd_chk("busy_flag", ADDR_GO, 32'd1);
      rd_chk("status_running", ADDR_STATUS, 32'd0);
`ifdef FACT_IRQ_EN
      check("irq_low_running", 32'(irq), 32'd0);
`endif
      @(negedge clk);
    end
    rd_chk("status_done", ADDR_STATUS, 32'({err, 1'b1}));
    rd_chk("result", ADDR_RESULT, res);
    rd_chk("busy_clear", ADDR_GO, 32'd0);
`ifdef FACT_IRQ_EN
    check("irq_set", 32'(irq), 32'd1);
`endif
    wr(ADDR_STATUS, $urandom);
`ifdef FACT_IRQ_EN
    check("irq_cleared", 32'(irq), 32'd0);
`endif
    rd_chk("status_after_wr", ADDR_STATUS, 32'({err, 1'b1}));
  endtask

  initial begin
    bus.WE = 1'b0;
    bus.A  = 2'b00;
    bus.WD = '0;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    rd_chk("rst_n", ADDR_N, 32'd0);
    rd_chk("rst_busy", ADDR_GO, 32'd0);
    rd_chk("rst_status", ADDR_STATUS, 32'd0);
    rd_chk("rst_result", ADDR_RESULT, 32'd0);
    @(negedge clk);
`ifdef FACT_IRQ_EN
    check("rst_irq", 32'(irq), 32'd0);
`endif

    run_job(5, 32'd1);
    run_job(0, 32'd1);
    run_job(1, 32'd1);
    run_job(12, 32'd1);
    check("fact12_const", fact_ref(12), 32'h1C8C_FC00);
    run_job(13, 32'd1);
    run_job(3, 32'd1);

    // GO with bit 0 clear leaves the finished job alone
    wr(ADDR_GO, 32'hFFFF_FFFE);
    rd_chk("go0_status", ADDR_STATUS, 32'd1);
    rd_chk("go0_result", ADDR_RESULT, 32'd6);
    rd_chk("go0_busy", ADDR_GO, 32'd0);

    // N write and GO while busy do not disturb the running n=6 job
    wr(ADDR_N, 32'd6);
    wr(ADDR_GO, 32'd1);
    wr(ADDR_N, 32'd2);
    wr(ADDR_GO, 32'd1);
    repeat (3) @(negedge clk);
    rd_chk("midjob_busy", ADDR_GO, 32'd1);
    rd_chk("midjob_status", ADDR_STATUS, 32'd0);
    @(negedge clk);
    rd_chk("midjob_status_done", ADDR_STATUS, 32'd1);
    rd_chk("midjob_result", ADDR_RESULT, 32'd720);
    rd_chk("midjob_n", ADDR_N, 32'd2);

    // Reset in the middle of a job abandons it
    wr(ADDR_N, 32'd6);
    wr(ADDR_GO, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd_chk("abort_n", ADDR_N, 32'd0);
    rd_chk("abort_busy", ADDR_GO, 32'd0);
    rd_chk("abort_status", ADDR_STATUS, 32'd0);
    rd_chk("abort_result", ADDR_RESULT, 32'd0);
    @(negedge clk);
`ifdef FACT_IRQ_EN
    check("abort_irq", 32'(irq), 32'd0);

    // STATUS write on the completion edge: set wins over clear
    wr(ADDR_N, 32'd2);
    wr(ADDR_GO, 32'd1);
    @(negedge clk);
    wr(ADDR_STATUS, 32'd0);
    check("irq_set_wins", 32'(irq), 32'd1);
    rd_chk("setwins_status", ADDR_STATUS, 32'd1);
    rd_chk("setwins_result", ADDR_RESULT, 32'd2);
    wr(ADDR_STATUS, 32'd0);
    check("irq_clear_after", 32'(irq), 32'd0);
`endif

    for (int k = 0; k < 16; k++) begin
      run_job(int'($urandom_range(0, 15)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
